// File: rtl/core_state_controller_if.sv
// Core state controller bus: run/memory/execute handshakes in, phase
// indicators, status flags and the retired-instruction count out.
// master = environment that drives the core controls,
// slave  = the state controller itself.
interface core_state_controller_if #(
   parameter int COUNT_WIDTH = 32
);
   logic                   run;
   logic                   memReady;
   logic                   multiCycleOp;
   logic                   executeDone;
   logic                   haltRequest;
   logic                   memRequest;
   logic                   fetch_RequestState;
   logic                   fetch_ReceiveState;
   logic                   decodeState;
   logic                   setupState;
   logic                   executeState;
   logic                   writebackState;
   logic                   halted;
   logic                   fault;
   logic [COUNT_WIDTH-1:0] instrCount;

   modport master (
      output run, memReady, multiCycleOp, executeDone, haltRequest,
      input  memRequest, fetch_RequestState, fetch_ReceiveState, decodeState,
             setupState, executeState, writebackState, halted, fault, instrCount
   );

   modport slave (
      input  run, memReady, multiCycleOp, executeDone, haltRequest,
      output memRequest, fetch_RequestState, fetch_ReceiveState, decodeState,
             setupState, executeState, writebackState, halted, fault, instrCount
   );
endinterface

// File: rtl/core_state_controller.sv
// Instruction sequencing FSM for the core:
//   IDLE -> FETCH_REQUEST -> FETCH_RECEIVE -> DECODE -> SETUP -> EXECUTE -> WRITEBACK
// with a fetch timeout into FAULT and a sticky halt that lets the in-flight
// instruction retire before entering HALTED. Every output is decoded from the
// state register only, so there is no input-to-output combinational path.
// Build option: define INSTR_COUNTER_EN to include the retired-instruction
// counter; when undefined the counter is absent and instrCount is tied to 0.
module core_state_controller #(
   parameter int FETCH_TIMEOUT = 16,   // 1..65535
   parameter int COUNT_WIDTH   = 32
) (
   input logic                    clk,
   input logic                    reset_n,
   core_state_controller_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE,
      FETCH_REQUEST,
      FETCH_RECEIVE,
      DECODE,
      SETUP,
      EXECUTE,
      WRITEBACK,
      HALTED,
      FAULT
   } stateT;

   // The wait counter holds cycles already spent waiting; the last permitted
   // waiting cycle is the one where it equals FETCH_TIMEOUT-1.
   localparam logic [15:0] WAIT_LAST = 16'(FETCH_TIMEOUT - 1);

   stateT       state;
   stateT       nextState;
   logic [15:0] waitCnt;
   logic        multiFlag;
   logic        haltPending;
   logic        haltSeen;

   // A halt pulse arriving this cycle counts the same as one already pending.
   assign haltSeen = haltPending | bus.haltRequest;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= nextState;
   end

   // Next-state rules.
   // NOTE: nextState gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (haltSeen)     nextState = HALTED;
            else if (bus.run) nextState = FETCH_REQUEST;
         end
         FETCH_REQUEST: begin
            // memReady wins over a timeout on the same cycle.
            if (bus.memReady)            nextState = FETCH_RECEIVE;
            else if (waitCnt == WAIT_LAST) nextState = FAULT;
         end
         FETCH_RECEIVE: nextState = DECODE;
         DECODE:        nextState = SETUP;
         SETUP:         nextState = EXECUTE;
         EXECUTE: begin
            if (!multiFlag || bus.executeDone) nextState = WRITEBACK;
         end
         WRITEBACK: begin
            if (haltSeen)     nextState = HALTED;
            else if (!bus.run) nextState = IDLE;
            else              nextState = FETCH_REQUEST;
         end
         HALTED:  nextState = HALTED;
         FAULT:   nextState = FAULT;
         default: nextState = IDLE;
      endcase
   end

   // Output decode from the registered state only.
   always_comb begin
      bus.memRequest         = 1'b0;
      bus.fetch_RequestState = 1'b0;
      bus.fetch_ReceiveState = 1'b0;
      bus.decodeState        = 1'b0;
      bus.setupState         = 1'b0;
      bus.executeState       = 1'b0;
      bus.writebackState     = 1'b0;
      bus.halted             = 1'b0;
      bus.fault              = 1'b0;
      case (state)
         FETCH_REQUEST: begin
            bus.memRequest         = 1'b1;
            bus.fetch_RequestState = 1'b1;
         end
         FETCH_RECEIVE: bus.fetch_ReceiveState = 1'b1;
         DECODE:        bus.decodeState        = 1'b1;
         SETUP:         bus.setupState         = 1'b1;
         EXECUTE:       bus.executeState       = 1'b1;
         WRITEBACK:     bus.writebackState     = 1'b1;
         HALTED:        bus.halted             = 1'b1;
         FAULT:         bus.fault              = 1'b1;
         default:       ;
      endcase
   end

   // Fetch wait counter: held at zero outside FETCH_REQUEST so every entry
   // starts a fresh count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                      waitCnt <= '0;
      else if (state != FETCH_REQUEST)                   waitCnt <= '0;
      else if (!bus.memReady && waitCnt != WAIT_LAST)    waitCnt <= waitCnt + 16'd1;
   end

   // Multi-cycle flag captured in DECODE, held through EXECUTE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)             multiFlag <= 1'b0;
      else if (state == DECODE) multiFlag <= bus.multiCycleOp;
   end

   // Sticky halt request, consumed when HALTED is entered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                 haltPending <= 1'b0;
      else if (nextState == HALTED) haltPending <= 1'b0;
      else if (bus.haltRequest)     haltPending <= 1'b1;
   end

`ifdef INSTR_COUNTER_EN
   logic [COUNT_WIDTH-1:0] instrCount;

   // Retired-instruction counter, wraps naturally at all-ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                instrCount <= '0;
      else if (state == WRITEBACK) instrCount <= instrCount + COUNT_WIDTH'(1);
   end

   assign bus.instrCount = instrCount;
`else
   assign bus.instrCount = '0;
`endif

endmodule

// File: doc/core_state_controller.md
CORE_STATE_CONTROLLER -- requirements
Module: core_state_controller

Interface
REQ-001 Parameter: FETCH_TIMEOUT, 16, cycles FETCH_REQUEST may wait for memReady before FAULT (legal 1..65535).
REQ-002 Parameter: COUNT_WIDTH, 32, width of the retired-instruction counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  level; 1 permits instruction sequencing.
REQ-006 memReady  input  1  instruction memory has valid data this cycle.
REQ-007 multiCycleOp  input  1  decoded instruction needs a multi-cycle execute; sampled in DECODE.
REQ-008 executeDone  input  1  multi-cycle execute unit finished.
REQ-009 haltRequest  input  1  single-cycle halt pulse, accepted in any state.
REQ-010 memRequest  output  1  instruction fetch request to memory.
REQ-011 fetch_RequestState, fetch_ReceiveState, decodeState, setupState, executeState, writebackState  output  1 each  one-hot phase indicators consumed by the frame write controller.
REQ-012 halted  output  1  core stopped by halt; fault  output  1  fetch timeout occurred.
REQ-013 instrCount  output  COUNT_WIDTH  retired-instruction count.

Function
REQ-014 States: IDLE, FETCH_REQUEST, FETCH_RECEIVE, DECODE, SETUP, EXECUTE, WRITEBACK, HALTED, FAULT; all outputs driven from registered state (no combinational input-to-output paths).
REQ-015 At most one of the six phase outputs high per cycle; all low in IDLE, HALTED, FAULT.
REQ-016 IDLE: run=1 -> FETCH_REQUEST next cycle; else stay.
REQ-017 FETCH_REQUEST: memRequest=1; memReady=1 -> FETCH_RECEIVE; else wait-counter increments; counter reaching FETCH_TIMEOUT with memReady=0 -> FAULT; counter clears on entry.
REQ-018 memReady=1 on the cycle the counter reaches FETCH_TIMEOUT: FETCH_RECEIVE wins.
REQ-019 FETCH_RECEIVE, DECODE, SETUP each last exactly one cycle, in that order.
REQ-020 DECODE latches multiCycleOp into an internal flag held through EXECUTE.
REQ-021 EXECUTE: flag=0 -> WRITEBACK after one cycle; flag=1 -> stay until executeDone=1, then WRITEBACK next cycle (executeDone in first EXECUTE cycle gives one-cycle EXECUTE).
REQ-022 executeDone outside EXECUTE is ignored.
REQ-023 WRITEBACK lasts one cycle; instrCount increments by 1, wrapping to 0 at all-ones.
REQ-024 WRITEBACK exit priority: pending halt -> HALTED; else run=0 -> IDLE; else FETCH_REQUEST.
REQ-025 haltRequest sets a sticky pending flag; instruction in flight completes; flag cleared on HALTED entry; haltRequest in IDLE -> HALTED next cycle.
REQ-026 run deassert mid-instruction has no effect until WRITEBACK.
REQ-027 HALTED: halted=1; FAULT: fault=1; both exit only via reset_n.
REQ-028 Minimum instruction latency (no stalls, memReady immediate): 6 cycles FETCH_REQUEST to WRITEBACK inclusive.

Reset
REQ-029 reset_n low asynchronously forces IDLE, memRequest=0, all phase outputs 0, halted=0, fault=0, instrCount=0, wait-counter=0, pending halt=0, multi-cycle flag=0, including mid-instruction.
REQ-030 First state advance occurs on the first rising clk edge after reset_n rises.

Configuration
REQ-031 Macro INSTR_COUNTER_EN: defined -> instrCount behaves per REQ-023; undefined -> counter logic absent and instrCount tied to 0.

Verification
REQ-032 Reset, run=1, memReady=1 always, multiCycleOp=0 -> phases cycle REQUEST..WRITEBACK every 6 cycles; instrCount=3 after 18 cycles (INSTR_COUNTER_EN defined).
REQ-033 memReady held 0, FETCH_TIMEOUT=4 -> FAULT on the 5th cycle after entering FETCH_REQUEST, fault=1, memRequest=0 thereafter until reset.
REQ-034 multiCycleOp=1, executeDone asserted 3 cycles after EXECUTE entry -> executeState high 4 cycles, then one writebackState cycle.
REQ-035 haltRequest pulse during SETUP -> instruction completes WRITEBACK, then halted=1; run toggling has no effect afterwards.
REQ-036 reset_n low during EXECUTE of a multi-cycle op -> immediate IDLE, all outputs 0; after release with run=1 -> FETCH_REQUEST, instrCount=0.
REQ-037 Macro undefined build: REQ-032 stimulus -> instrCount stays 0.
